// File: rtl/muldiv_unit_if.sv
// Bus between the control unit and the iterative multiply/divide engine.
// The control side (master) issues start/op/sgn/operands; the engine (slave)
// returns the Hi/Lo results and the busy/done/dzero status.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             dzero;

    modport master (
        output start, op, sgn, a, b,
        input  hi, lo, busy, done, dzero
    );

    modport slave (
        input  start, op, sgn, a, b,
        output hi, lo, busy, done, dzero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide engine.
// A single 2*WIDTH accumulator is shared by both operations: multiply uses
// shift-add with the multiplier in the low half, divide uses restoring
// division with {remainder, dividend/quotient} packed in the accumulator.
// Signs are stripped at acceptance and reapplied when the result is written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    // DZ_WAIT is the single non-busy cycle between accepting a divide by
    // zero and reporting it, so the flag arrives one edge after acceptance.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DZ_WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             div_zero_req;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic             op_q;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;
    logic             last_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes and the acceptance condition, from the live inputs.
    always_comb begin
        mag_a        = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b        = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        div_zero_req = bus.op && (bus.b == '0);
        accept       = bus.start && ((state == IDLE) || (state == DONE));
    end

    // One iteration of each algorithm plus the sign-corrected final results.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step = {add_sum, acc[WIDTH-1:1]};
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        div_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = div_zero_req ? DZ_WAIT : RUN;
                end
            end
            RUN: begin
                if (last_q) begin
                    state_next = DONE;
                end
            end
            DZ_WAIT: begin
                state_next = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_next = div_zero_req ? DZ_WAIT : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on acceptance, iterate in RUN, then write Hi/Lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            last_q <= 1'b0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (accept) begin
            op_q   <= bus.op;
            neg_q  <= bus.sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= bus.sgn && bus.a[WIDTH-1];
            dz_q   <= div_zero_req;
            last_q <= 1'b0;
            cnt    <= CW'(WIDTH - 1);
            opnd   <= bus.op ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, (bus.op ? mag_a : mag_b)};
        end else if (state == RUN) begin
            if (!last_q) begin
                acc <= op_q ? div_step : mul_step;
                if (cnt == '0) begin
                    last_q <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else if (op_q) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                lo_q <= prod_fix[WIDTH-1:0];
            end
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.dzero = (state == DONE) && dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance share
// clock and reset; expected results are queued at acceptance and checked
// when each instance raises done, including the completion edge number.
module tb_muldiv_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_edge;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_cnt;
    int   vectors;
    int   miscompares;
    int   done_cnt [2];
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];
    exp_t qa[$];
    exp_t qb[$];

    muldiv_unit_if #(.WIDTH(32)) bus_a ();
    muldiv_unit_if #(.WIDTH(8))  bus_b ();

    muldiv_unit #(.WIDTH(32)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    muldiv_unit #(.WIDTH(8))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic void model(input int w, input logic op, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] mask, ua, ub, p;
        longint sa, sb, sq, sr;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        dz = 1'b0;
        hi = prev_hi;
        lo = prev_lo;
        if (!op) begin
            p  = sgn ? 64'(sa * sb) : ua * ub;
            lo = 32'(p & mask);
            hi = 32'((p >> w) & mask);
        end else if (ub == 64'd0) begin
            dz = 1'b1;
        end else if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            lo = 32'(64'(sq) & mask);
            hi = 32'(64'(sr) & mask);
        end else begin
            lo = 32'((ua / ub) & mask);
            hi = 32'((ua % ub) & mask);
        end
    endfunction

    task automatic pushExpected(input bit inst, input logic op, input logic sgn,
                                input logic [31:0] a, input logic [31:0] b, input int e0);
        exp_t e;
        int   w;
        w = inst ? 8 : 32;
        model(w, op, sgn, a, b, mhi[inst], mlo[inst], e.hi, e.lo, e.dz);
        e.done_edge = e0 + (e.dz ? 1 : w + 1);
        mhi[inst] = e.hi;
        mlo[inst] = e.lo;
        if (inst) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic driveOperands(input bit inst, input logic st, input logic op, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b);
        if (!inst) begin
            bus_a.start = st; bus_a.op = op; bus_a.sgn = sgn; bus_a.a = a; bus_a.b = b;
        end else begin
            bus_b.start = st; bus_b.op = op; bus_b.sgn = sgn; bus_b.a = a[7:0]; bus_b.b = b[7:0];
        end
    endtask

    task automatic applyStimulus(input bit inst, input logic op, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b);
        int e0;
        driveOperands(inst, 1'b1, op, sgn, a, b);
        @(posedge clk);
        #1;
        e0 = edge_cnt;
        driveOperands(inst, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
        pushExpected(inst, op, sgn, a, b, e0);
    endtask

    task automatic waitIdle(input bit inst);
        int n;
        n = 0;
        while (((inst ? qb.size() : qa.size()) != 0) && (n < 300)) begin
            @(posedge clk);
            n++;
        end
        if ((inst ? qb.size() : qa.size()) != 0) begin
            checkOutput(inst ? "B.timeout" : "A.timeout", 32'(inst ? qb.size() : qa.size()), 32'd0);
            if (inst) qb.delete();
            else      qa.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkDone(input bit inst, input logic [31:0] hi, input logic [31:0] lo,
                             input logic dz, input logic busy, input logic done);
        exp_t  e;
        string p;
        p = inst ? "B." : "A.";
        if ((inst ? qb.size() : qa.size()) == 0) begin
            checkOutput({p, "unexpected_done"}, 32'(done), 32'd0);
        end else begin
            e = inst ? qb.pop_front() : qa.pop_front();
            checkOutput({p, "hi"}, hi, e.hi);
            checkOutput({p, "lo"}, lo, e.lo);
            checkOutput({p, "dzero"}, 32'(dz), 32'(e.dz));
            checkOutput({p, "done_edge"}, 32'(edge_cnt), 32'(e.done_edge));
            checkOutput({p, "busy_at_done"}, 32'(busy), 32'd0);
        end
    endtask

    // Result monitor: every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus_a.done) begin
            done_cnt[0]++;
            checkDone(1'b0, bus_a.hi, bus_a.lo, bus_a.dzero, bus_a.busy, bus_a.done);
        end
        if (bus_b.done) begin
            done_cnt[1]++;
            checkDone(1'b1, {24'd0, bus_b.hi}, {24'd0, bus_b.lo}, bus_b.dzero, bus_b.busy, bus_b.done);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int e1;
        int snap;
        logic [31:0] ra, rb;

        edge_cnt    = 0;
        vectors     = 0;
        miscompares = 0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        for (int i = 0; i < 2; i++) begin
            mhi[i] = 32'd0;
            mlo[i] = 32'd0;
        end
        reset = 1'b1;
        driveOperands(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        driveOperands(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("A.rst_hi", bus_a.hi, 32'd0);
        checkOutput("A.rst_lo", bus_a.lo, 32'd0);
        checkOutput("A.rst_busy", 32'(bus_a.busy), 32'd0);
        checkOutput("A.rst_done", 32'(bus_a.done), 32'd0);
        checkOutput("A.rst_dzero", 32'(bus_a.dzero), 32'd0);
        checkOutput("B.rst_hi", {24'd0, bus_b.hi}, 32'd0);
        checkOutput("B.rst_lo", {24'd0, bus_b.lo}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Signed and unsigned multiply / divide corner cases
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5);        waitIdle(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF); waitIdle(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF); waitIdle(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);        waitIdle(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF); waitIdle(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80000000, 32'h80000000); waitIdle(1'b0);

        // Back-to-back with start held high across the DONE cycle
        driveOperands(1'b0, 1'b1, 1'b0, 1'b1, 32'h00012345, 32'hFFFF0001);
        @(posedge clk);
        #1;
        e0 = edge_cnt;
        pushExpected(1'b0, 1'b0, 1'b1, 32'h00012345, 32'hFFFF0001, e0);
        driveOperands(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00001234);
        repeat (34) @(posedge clk);
        #1;
        e1 = edge_cnt;
        driveOperands(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        pushExpected(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00001234, e1);
        waitIdle(1'b0);

        // Divide by zero leaves Hi/Lo untouched and never raises busy
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h00003412, 32'h00000100); waitIdle(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd9, 32'd0);
        @(negedge clk);
        checkOutput("A.dz_busy", 32'(bus_a.busy), 32'd0);
        waitIdle(1'b0);

        // Random mixed operations on the 32-bit instance
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), ra, rb);
            waitIdle(1'b0);
        end

        // 8-bit instance
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd200, 32'd7);  waitIdle(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80, 32'hFF);  waitIdle(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 32'h80);  waitIdle(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h55, 32'h00);  waitIdle(1'b1);
        for (int i = 0; i < 12; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(1, 255));
            applyStimulus(1'b1, 1'($urandom), 1'($urandom), ra, rb);
            waitIdle(1'b1);
        end

        // A start pulse during RUN must be ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd7, 32'd6);
        repeat (8) @(posedge clk);
        #1;
        driveOperands(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd100);
        @(posedge clk);
        #1;
        driveOperands(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("A.busy_ignored", 32'(bus_a.busy), 32'd1);
        waitIdle(1'b0);

        // Reset in the middle of RUN aborts without a done pulse
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h00001234, 32'h00005678);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("A.abort_hi", bus_a.hi, 32'd0);
        checkOutput("A.abort_lo", bus_a.lo, 32'd0);
        checkOutput("A.abort_busy", 32'(bus_a.busy), 32'd0);
        checkOutput("A.abort_done", 32'(bus_a.done), 32'd0);
        checkOutput("A.abort_dzero", 32'(bus_a.dzero), 32'd0);
        checkOutput("B.abort_hi", {24'd0, bus_b.hi}, 32'd0);
        checkOutput("B.abort_lo", {24'd0, bus_b.lo}, 32'd0);
        qa.delete();
        for (int i = 0; i < 2; i++) begin
            mhi[i] = 32'd0;
            mlo[i] = 32'd0;
        end
        snap = done_cnt[0];
        @(negedge clk);
        reset = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        checkOutput("A.no_done_after_abort", 32'(done_cnt[0] - snap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
